// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue; one outstanding IMEM request, redirect flush.
// Optional define FETCH_PERF_EN adds PerfFetched/PerfBubble counters.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            StallD,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     PerfFetched,
  output logic [31:0]     PerfBubble
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            pending_q, pending_d, discard_q, discard_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] epc_q   [DEPTH];
  logic            issue, resp, push, pop;

  always_comb begin
    issue     = rst && !pending_q && !PCSrcE && (count_q < CW'(DEPTH));
    resp      = imem_rvalid && pending_q;
    push      = resp && !discard_q && !PCSrcE;
    pop       = (count_q != '0) && !StallD && !PCSrcE;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    pending_d = pending_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (PCSrcE) begin
      pc_d     = PCTargetE & ~XLEN'(3);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // An in-flight response still has to be absorbed before the target can issue.
      if (pending_q) begin
        if (imem_rvalid) begin
          pending_d = 1'b0;
          discard_d = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      if (issue) begin
        pc_d      = pc_q + XLEN'(4);
        req_pc_d  = pc_q;
        pending_d = 1'b1;
      end
      if (resp) begin
        pending_d = 1'b0;
        discard_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      pending_q <= 1'b0;
      discard_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      epc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign ValidD    = (count_q != '0);
  assign InstrD    = rst ? instr_q[rd_ptr_q] : '0;
  assign PCD       = rst ? epc_q[rd_ptr_q] : '0;
  assign PCPlus4D  = rst ? epc_q[rd_ptr_q] + XLEN'(4) : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      bubble_q  <= '0;
    end else begin
      if (pop)             fetched_q <= fetched_q + 32'd1;
      if (count_q == '0)   bubble_q  <= bubble_q + 32'd1;
    end
  end

  assign PerfFetched = fetched_q;
  assign PerfBubble  = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed tables/sequences plus random traffic vs a queue model.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0, rst = 1'b0, PCSrcE = 1'b0, imem_rvalid = 1'b0, StallD = 1'b0;
  logic [31:0] PCTargetE = '0, imem_rdata = '0;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_EN
  logic [31:0] PerfFetched, PerfBubble;
`endif

  fetch_queue_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallD(StallD), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
`ifdef FETCH_PERF_EN
    , .PerfFetched(PerfFetched), .PerfBubble(PerfBubble)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc, m_req_pc, m_fetched, m_bubble;
  bit          m_pending, m_discard;

  int          resp_cnt = 0, lat_cfg = 1;
  logic [31:0] resp_data = '0;
  bit          stray_en = 0, force_stray = 0;
  bit          obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pcd, obs_instr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC; m_req_pc = '0; m_pending = 0; m_discard = 0;
    m_fetched = '0; m_bubble = '0;
  endtask

  // One clock: drive IMEM response, check outputs mid-cycle, advance the model on the edge.
  task automatic step(string tag);
    bit exp_req, resp, pop;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst) resp_cnt = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = resp_data; end
    end else if (force_stray || (stray_en && !m_pending && $urandom_range(7) == 0)) begin
      imem_rvalid = 1'b1;
    end
    force_stray = 0;
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = ValidD; obs_pcd = PCD; obs_instr = InstrD;
    exp_req = rst && !m_pending && !PCSrcE && (mq.size() < DEPTH);
    chk({tag, " imem_req"}, 32'(imem_req), 32'(exp_req));
    if (exp_req) chk({tag, " imem_addr"}, imem_addr, m_pc);
    chk({tag, " ValidD"}, 32'(ValidD), 32'(rst && mq.size() != 0));
    if (!rst) begin
      chk({tag, " InstrD rst"}, InstrD, 32'h0);
      chk({tag, " PCD rst"}, PCD, 32'h0);
      chk({tag, " PCPlus4D rst"}, PCPlus4D, 32'h0);
    end else if (mq.size() != 0) begin
      chk({tag, " InstrD"}, InstrD, mq[0].instr);
      chk({tag, " PCD"}, PCD, mq[0].pc);
      chk({tag, " PCPlus4D"}, PCPlus4D, mq[0].pc + 32'd4);
    end
`ifdef FETCH_PERF_EN
    chk({tag, " PerfFetched"}, PerfFetched, rst ? m_fetched : 32'h0);
    chk({tag, " PerfBubble"}, PerfBubble, rst ? m_bubble : 32'h0);
`endif
    if (imem_req === 1'b1) begin
      resp_cnt  = lat_cfg;
      resp_data = mem_word(imem_addr);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (mq.size() == 0) m_bubble++;
      if (PCSrcE) begin
        mq.delete();
        m_pc = PCTargetE & ~32'h3;
        if (m_pending) begin
          if (imem_rvalid) begin m_pending = 0; m_discard = 0; end
          else m_discard = 1;
        end
      end else begin
        resp = imem_rvalid && m_pending;
        pop  = (mq.size() != 0) && !StallD;
        if (pop) begin
          $display("%s pop pc=%h instr=%h", tag, mq[0].pc, mq[0].instr);
          m_fetched++;
          void'(mq.pop_front());
        end
        if (resp) begin
          if (!m_discard) mq.push_back('{imem_rdata, m_req_pc});
          m_pending = 0; m_discard = 0;
        end
        if (exp_req) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_pending = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    PCSrcE = 0; StallD = 0; stray_en = 0; lat_cfg = 1; rst = 0;
    step("reset");
    step("reset");
    rst = 1;
  endtask

  typedef struct { bit stall; bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pcd; } vec_t;
  vec_t t1[6];

  initial begin
    int nreq;
    logic [31:0] last_addr, first_addr;
    bit got_first;

    t1[0] = '{0, 1, 32'h0, 0, 32'h0};
    t1[1] = '{0, 0, 32'h0, 0, 32'h0};
    t1[2] = '{0, 1, 32'h4, 1, 32'h0};
    t1[3] = '{0, 0, 32'h0, 0, 32'h0};
    t1[4] = '{0, 1, 32'h8, 1, 32'h4};
    t1[5] = '{0, 0, 32'h0, 0, 32'h0};

    @(negedge clk);
    do_reset();

    // Latency 1, no stall: one request every two cycles.
    for (int i = 0; i < 6; i++) begin
      StallD = t1[i].stall;
      step("t1");
      chk("t1 tbl req", 32'(obs_req), 32'(t1[i].exp_req));
      if (t1[i].exp_req) chk("t1 tbl addr", obs_addr, t1[i].exp_addr);
      chk("t1 tbl valid", 32'(obs_valid), 32'(t1[i].exp_valid));
      if (t1[i].exp_valid) begin
        chk("t1 tbl pcd", obs_pcd, t1[i].exp_pcd);
        chk("t1 tbl instr", obs_instr, mem_word(t1[i].exp_pcd));
      end
    end

    // Decode stalled for 20 cycles: queue fills, issue stops, then drains in order.
    do_reset();
    StallD = 1; nreq = 0; last_addr = '1;
    for (int i = 0; i < 20; i++) begin
      step("t2");
      if (obs_req) begin nreq++; last_addr = obs_addr; end
      if (i >= 2) chk("t2 held pcd", obs_pcd, 32'h0);
    end
    chk("t2 req count", 32'(nreq), 32'd4);
    chk("t2 last addr", last_addr, 32'hC);
    StallD = 0; got_first = 0; first_addr = '1;
    for (int i = 0; i < 4; i++) begin
      step("t2");
      chk("t2 pop order", obs_pcd, 32'(i * 4));
      if (obs_req && !got_first) begin got_first = 1; first_addr = obs_addr; end
    end
    chk("t2 resume addr", first_addr, 32'h10);

    // Redirect while a latency-3 request to 0x8 is outstanding.
    do_reset();
    StallD = 1;
    for (int i = 0; i < 4; i++) step("t3");
    lat_cfg = 3;
    step("t3");
    chk("t3 req 8", obs_addr, 32'h8);
    lat_cfg = 1;
    PCSrcE = 1; PCTargetE = 32'h103;
    step("t3");
    PCSrcE = 0; StallD = 0;
    step("t3");
    chk("t3 flushed", 32'(obs_valid), 32'd0);
    chk("t3 no req pending", 32'(obs_req), 32'd0);
    step("t3");
    chk("t3 no req on drop", 32'(obs_req), 32'd0);
    step("t3");
    chk("t3 target req", 32'(obs_req), 32'd1);
    chk("t3 target addr", obs_addr, 32'h100);
    step("t3");
    step("t3");
    chk("t3 target valid", 32'(obs_valid), 32'd1);
    chk("t3 target pcd", obs_pcd, 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    StallD = 1;
    for (int i = 0; i < 3; i++) step("t4");
    StallD = 0; PCSrcE = 1; PCTargetE = 32'h200;
    step("t4");
    chk("t4 valid before", 32'(obs_valid), 32'd1);
    PCSrcE = 0;
    step("t4");
    chk("t4 nothing pushed", 32'(obs_valid), 32'd0);
    chk("t4 target req", 32'(obs_req), 32'd1);
    chk("t4 target addr", obs_addr, 32'h200);

    // Reset with a request pending and three queued entries; stray response after release.
    do_reset();
    StallD = 1;
    for (int i = 0; i < 6; i++) step("t5");
    lat_cfg = 5;
    step("t5");
    chk("t5 req C", obs_addr, 32'hC);
    lat_cfg = 1;
    rst = 0;
    step("t5");
    chk("t5 rst valid", 32'(obs_valid), 32'd0);
    chk("t5 rst pcd", obs_pcd, 32'd0);
    step("t5");
    rst = 1; StallD = 0; force_stray = 1;
    step("t5");
    chk("t5 first addr", obs_addr, RESET_PC);
    step("t5");
    step("t5");
    chk("t5 first pcd", obs_pcd, RESET_PC);
    chk("t5 first instr", obs_instr, mem_word(RESET_PC));

    // Random traffic against the reference model.
    do_reset();
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(299) != 0);
      StallD    = ((i / 250) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      PCSrcE    = ($urandom_range(15) == 0);
      PCTargetE = $urandom;
      lat_cfg   = $urandom_range(1, 4);
      step("rnd");
    end
    rst = 1; PCSrcE = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage. It owns the PC and issues word fetches to an instruction memory over a request/response handshake with variable latency. Returned instructions are buffered in a DEPTH-entry prefetch queue, so fetch continues while decode is stalled. An execute-stage redirect flushes the queue and steers the PC. The block sits between the PC/IMEM side and the decode stage.

Parameters:
XLEN, 32, instruction and address width
RESET_PC, 32'h00000000, PC value loaded on reset
DEPTH, 4, prefetch queue entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
PCSrcE  in  1  redirect request from execute
PCTargetE  in  XLEN  redirect target address
imem_req  out  1  fetch request valid, one cycle per request
imem_addr  out  XLEN  fetch address, valid with imem_req
imem_rvalid  in  1  response valid
imem_rdata  in  XLEN  response instruction word
StallD  in  1  decode not ready
ValidD  out  1  head entry valid
InstrD  out  XLEN  head instruction
PCD  out  XLEN  head PC
PCPlus4D  out  XLEN  head PC + 4

Behaviour:
- Reset (rst=0, async) sets:
  - PC=RESET_PC; queue count=0; pending=0; discard=0.
  - imem_req=0 and ValidD=0.
  - InstrD, PCD and PCPlus4D read 0 while rst=0.
- Issue rules:
  - At most one outstanding request.
  - imem_req=1 when: pending=0, PCSrcE=0, and count < DEPTH.
  - imem_addr = PC on an issue cycle. The next edge sets PC <= PC+4 (mod 2^XLEN) and pending <= 1, and records req_pc = PC.
- Response:
  - imem_rvalid can arrive no earlier than 1 cycle after the request; there is no upper bound.
  - If pending=1 and discard=0: push {imem_rdata, req_pc, req_pc+4}.
  - If discard=1: drop the data.
  - Either way, pending <= 0 and discard <= 0.
  - imem_rvalid while pending=0 is ignored.
- Queue:
  - Circular register FIFO with rd/wr pointers of log2(DEPTH) bits that wrap naturally.
  - Outputs are driven combinationally from the head entry, so a pushed entry is visible the cycle after the push. No same-cycle bypass.
  - ValidD = (count != 0).
  - Pop when ValidD=1 and StallD=0.
  - Push and pop in the same cycle: count unchanged.
  - Cannot overflow: issue already requires count < DEPTH, and only one request is outstanding.
- Redirect (PCSrcE=1), which takes priority over all other events:
  - Queue flushed (count=0, pointers=0). Any pop or push that cycle is cancelled.
  - PC <= {PCTargetE[XLEN-1:2], 2'b00}.
  - No issue that cycle.
  - If a request is in flight and its response is not arriving this cycle: discard <= 1.
  - If the response arrives in the same cycle: it is dropped and pending clears.
  - Issue from the target resumes the first cycle with pending=0 and PCSrcE=0.
  - Back-to-back redirects: the last target wins.
- Reset mid-operation clears pending and the queue. A late response after reset release is ignored, because pending=0.
- StallD held indefinitely: the queue fills to DEPTH, then issue stops. Entries are retained unchanged.

Optional Feature:
FETCH_PERF_EN
- Defined: adds two output ports.
  - PerfFetched (32 bits): increments on every pop.
  - PerfBubble (32 bits): increments on every cycle with rst=1 and ValidD=0.
  - Both are cleared by reset, wrap at 2^32, and are not cleared by a redirect.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset release, IMEM latency 1, StallD=0:
   - imem_addr sequence 0x0, 0x4, 0x8 …, one request every 2 cycles.
   - PCD=0x0 with PCPlus4D=0x4, then PCD=0x4.
   - InstrD matches the memory contents.
2. StallD=1 for 20 cycles, latency 1, DEPTH=4:
   - Exactly 4 requests (0x0–0xC), then imem_req=0.
   - ValidD=1 and PCD=0x0 held throughout.
   - On release, pops occur in order 0x0, 0x4, 0x8, 0xC, then fetching resumes at 0x10.
3. Latency 3 with a request to 0x8 outstanding; PCSrcE=1, PCTargetE=0x103 for one cycle:
   - Queue empties (ValidD=0 the next cycle).
   - The response for 0x8 is dropped.
   - The next imem_addr is 0x100, issued the cycle after that response.
4. Redirect in the same cycle as imem_rvalid and a pop:
   - Nothing pushed, nothing delivered.
   - The next request goes to the target.
5. rst asserted while a request is pending and the queue holds 3 entries:
   - Outputs go to 0 immediately.
   - A stray imem_rvalid after release is ignored.
   - The first imem_addr is RESET_PC.
6. FETCH_PERF_EN defined, 10 pops and 4 bubble cycles after reset:
   - PerfFetched=10 and PerfBubble=4.
   - Counters unchanged across a redirect.
